// File: rtl/instr_sequencer.sv
// Instruction front end: buffers 10-bit words in a FIFO, fetches them into INSTR
// and steps the timestep T for the step-decoding controller.
module instr_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [9:0]       in_instr,
    output logic             in_ready,
    input  logic             run,
    input  logic             IRin,
    input  logic             Clr,
    output logic [9:0]       INSTR,
    output logic [1:0]       T,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_count,
    output logic             seq_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t           state;
    logic [9:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             push;
    logic             pop;

    // Readiness looks only at registered occupancy, so a same-cycle fetch never frees a slot.
    assign in_ready = (occ < FULL_OCC);
    assign push     = in_valid && in_ready;
    assign pop      = run && (state == IDLE) && IRin && (occ != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            state       <= IDLE;
            INSTR       <= '0;
            T           <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            instr_count <= '0;
            seq_err     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (pop && !push) begin
                occ <= occ - OCC_W'(1);
            end

            done <= 1'b0;
            if (run) begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            INSTR <= mem[rd_ptr];
                            T     <= 2'd1;
                            busy  <= 1'b1;
                            state <= EXEC;
                        end
                    end
                    EXEC: begin
                        if (Clr) begin
                            T           <= 2'd0;
                            done        <= 1'b1;
                            instr_count <= instr_count + CNT_W'(1);
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else if (T != 2'd3) begin
                            T <= T + 2'd1;
                        end else begin
                            // Controller ran past the last timestep without ending the instruction.
                            seq_err <= 1'b1;
                            T       <= 2'd0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        T     <= 2'd0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: pushed words queue up as expected fetches,
// the bench plays the controller and checks T, done, count and error flag.
module tb_instr_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [9:0]       in_instr;
    logic             in_ready;
    logic             run;
    logic             IRin;
    logic             Clr;
    logic [9:0]       INSTR;
    logic [1:0]       T;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] instr_count;
    logic             seq_err;

    instr_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .run(run), .IRin(IRin), .Clr(Clr), .INSTR(INSTR),
        .T(T), .busy(busy), .done(done), .instr_count(instr_count), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    logic [9:0]       exp_q[$];
    logic [CNT_W-1:0] exp_count;
    int               checks;
    int               errors;
    int               cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cycles++;
        #1;
    endtask

    task automatic push_word(input logic [9:0] w);
        in_valid = 1'b1;
        in_instr = w;
        check("push_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        tick();
        in_valid = 1'b0;
    endtask

    // Fetch the queue head, optionally freeze at T=1 and optionally push in the fetch cycle;
    // clr_t > 3 means the controller never ends the instruction.
    task automatic exec_instr(input int clr_t, input int hold, input bit push_en, input logic [9:0] pw);
        logic [9:0] w;
        bit         acc;
        acc = exp_q.size() < DEPTH;
        if (exp_q.size() == 0) begin
            check("exec_queue_nonempty", 32'(exp_q.size()), 32'd1);
            return;
        end
        w = exp_q.pop_front();
        if (push_en) begin
            in_valid = 1'b1;
            in_instr = pw;
            check("fetch_push_ready", 32'(in_ready), 32'(acc));
            if (acc) exp_q.push_back(pw);
        end
        IRin = 1'b1;
        tick();
        IRin     = 1'b0;
        in_valid = 1'b0;
        check("fetch_instr", 32'(INSTR), 32'(w));
        check("fetch_t", 32'(T), 32'd1);
        check("fetch_busy", 32'(busy), 32'd1);
        check("fetch_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
        if (hold > 0) begin
            run = 1'b0;
            repeat (hold) begin
                tick();
                check("hold_t", 32'(T), 32'd1);
                check("hold_done", 32'(done), 32'd0);
            end
            run = 1'b1;
        end
        for (int t = 1; t <= 3; t++) begin
            if (t == clr_t) begin
                Clr = 1'b1;
                tick();
                Clr = 1'b0;
                exp_count++;
                check("retire_t", 32'(T), 32'd0);
                check("retire_done", 32'(done), 32'd1);
                check("retire_busy", 32'(busy), 32'd0);
                check("retire_count", 32'(instr_count), 32'(exp_count));
                check("retire_instr", 32'(INSTR), 32'(w));
                return;
            end
            tick();
            if (t < 3) begin
                check("step_t", 32'(T), 32'(t + 1));
                check("step_busy", 32'(busy), 32'd1);
                check("step_done", 32'(done), 32'd0);
            end else begin
                check("ovf_t", 32'(T), 32'd0);
                check("ovf_seq_err", 32'(seq_err), 32'd1);
                check("ovf_done", 32'(done), 32'd0);
                check("ovf_busy", 32'(busy), 32'd0);
                check("ovf_count", 32'(instr_count), 32'(exp_count));
            end
        end
    endtask

    task automatic check_idle_empty();
        IRin = 1'b1;
        tick();
        IRin = 1'b0;
        check("empty_fetch_t", 32'(T), 32'd0);
        check("empty_fetch_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int c0;
        int len_plain;
        int len_hold;
        checks    = 0;
        errors    = 0;
        cycles    = 0;
        exp_count = '0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        run       = 1'b1;
        IRin      = 1'b0;
        Clr       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_instr", 32'(INSTR), 32'd0);
        check("rst_t", 32'(T), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_seq_err", 32'(seq_err), 32'd0);

        // LOAD: retires at T=1
        push_word(10'b00_01_00_0000);
        exec_instr(1, 0, 1'b0, '0);
        tick();
        check("load_done_low", 32'(done), 32'd0);

        // ADD immediate: retires at T=3
        push_word(10'b10_10_000101);
        exec_instr(3, 0, 1'b0, '0);

        // Back-to-back COPY then INV, plain and with a 2-cycle freeze at T=1
        push_word(10'b01_00_01_0010);
        push_word(10'b01_11_00_0100);
        c0 = cycles;
        exec_instr(1, 0, 1'b0, '0);
        exec_instr(2, 0, 1'b0, '0);
        len_plain = cycles - c0;
        check("b2b_len", 32'(len_plain), 32'd5);
        check("b2b_count", 32'(instr_count), 32'd4);
        push_word(10'b01_00_10_0011);
        push_word(10'b01_10_00_0101);
        c0 = cycles;
        exec_instr(1, 2, 1'b0, '0);
        exec_instr(2, 0, 1'b0, '0);
        len_hold = cycles - c0;
        check("b2b_hold_len", 32'(len_hold), 32'(len_plain + 2));

        // FIFO full, dropped word, and simultaneous push+fetch at full
        for (int i = 0; i < DEPTH; i++) push_word(10'h300 + 10'(i * 17));
        check("full_ready", 32'(in_ready), 32'd0);
        push_word(10'h155);
        exec_instr(2, 0, 1'b1, 10'h2AA);
        exec_instr(1, 0, 1'b0, '0);
        exec_instr(3, 0, 1'b0, '0);
        exec_instr(2, 0, 1'b0, '0);
        check_idle_empty();

        // Missing Clr overflows T
        push_word(10'b11_01_10_1001);
        exec_instr(4, 0, 1'b0, '0);
        tick();
        check("ovf_sticky", 32'(seq_err), 32'd1);

        // Clr in IDLE is ignored
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        check("idle_clr_done", 32'(done), 32'd0);
        check("idle_clr_count", 32'(instr_count), 32'(exp_count));

        // Reset in the middle of an instruction with 2 words queued
        push_word(10'h0F1);
        push_word(10'h0F2);
        push_word(10'h0F3);
        IRin = 1'b1;
        tick();
        IRin = 1'b0;
        tick();
        check("pre_rst_t", 32'(T), 32'd2);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_instr = 10'h3FF;
        Clr      = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        Clr      = 1'b0;
        exp_q.delete();
        exp_count = '0;
        check("mid_rst_t", 32'(T), 32'd0);
        check("mid_rst_instr", 32'(INSTR), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_seq_err", 32'(seq_err), 32'd0);
        check("mid_rst_count", 32'(instr_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check_idle_empty();

        // Sequencing resumes cleanly after reset
        push_word(10'h2C3);
        exec_instr(2, 0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
